// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg -- shared definitions for the mips_sopc pipeline.
//   - word and register-index typedefs
//   - opcode / funct encodings of the supported logic-operation subset
//   - ALU operation enum and the canonical NOP instruction word
//   - pipeline latch structs (ID/EX and the EX/MEM, MEM/WB write-back bundle)
//   - alu() helper evaluated in the EX stage
// ============================================================================
package mips_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    // sll $0,$0,0 -- also what the ROM returns when disabled or out of range
    localparam word_t NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_LUI
    } alu_op_e;

    // ID/EX latch: decoded operation plus resolved operands
    typedef struct packed {
        alu_op_e  op;
        word_t    a;
        word_t    b;
        reg_idx_t wd;
        logic     we;
    } id_ex_t;

    // EX/MEM and MEM/WB latches: a pending register-file write
    typedef struct packed {
        logic     we;
        reg_idx_t wd;
        word_t    data;
    } wb_t;

    function automatic word_t alu(input alu_op_e op, input word_t a, input word_t b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_NOR: return ~(a | b);
            ALU_LUI: return {b[15:0], 16'h0000};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mips_rom.sv
// ============================================================================
// mips_rom -- instruction ROM with combinational read.
//   Ports:
//     ce_i    read enable; when low the ROM returns NOP
//     addr_i  word index (pc[11:2])
//     inst_o  instruction word; NOP when disabled or index >= ROM_DEPTH
//   The storage array is filled from outside (hierarchically, by the
//   simulation environment); it has no write port.
// ============================================================================
module mips_rom
    import mips_pkg::*;
#(
    parameter int ROM_DEPTH = 1024
) (
    input  logic       ce_i,
    input  logic [9:0] addr_i,
    output word_t      inst_o
);

    word_t storage [0:ROM_DEPTH-1];

    always_comb begin
        inst_o = NOP;
        if (ce_i && (int'(addr_i) < ROM_DEPTH)) begin
            inst_o = storage[addr_i];
        end
    end

endmodule

// File: rtl/mips_sopc.sv
// ============================================================================
// mips_sopc -- minimal MIPS system-on-chip: 5-stage in-order pipeline
// (IF, ID, EX, MEM, WB) running ORI/ANDI/XORI/LUI and SPECIAL AND/OR/XOR/NOR.
// Anything else retires as a NOP. No branches, loads, stores or stalls.
//   Ports:
//     clock  system clock, all state changes on the rising edge
//     reset  asynchronous, active-high reset
//   Hierarchical observation points: rom.storage[], regs[], pc_q.
//   Build option: MIPS_FORWARD_EN -- forward EX and MEM results into ID.
//   Without it only the WB-to-ID register-file bypass exists, so a consumer
//   must sit at least 3 instructions behind its producer.
// ============================================================================
module mips_sopc
    import mips_pkg::*;
#(
    parameter int ROM_DEPTH = 1024
) (
    input logic clock,
    input logic reset
);

    // ---------------------------------------------------------------- IF
    word_t pc_q;
    word_t pc_d;
    word_t rom_inst;
    logic  rom_ce;

    assign pc_d   = pc_q + 32'd4;
    // Reading is gated by reset directly so the first edge after release
    // already captures word 0.
    assign rom_ce = ~reset;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    mips_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
        .ce_i   (rom_ce),
        .addr_i (pc_q[11:2]),
        .inst_o (rom_inst)
    );

    word_t if_id_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) if_id_q <= NOP;
        else       if_id_q <= rom_inst;
    end

    // ---------------------------------------------------------------- ID
    logic [5:0] opcode;
    logic [5:0] funct;
    reg_idx_t   rs;
    reg_idx_t   rt;
    reg_idx_t   rd;
    logic [15:0] imm;

    assign opcode = if_id_q[31:26];
    assign rs     = if_id_q[25:21];
    assign rt     = if_id_q[20:16];
    assign rd     = if_id_q[15:11];
    assign imm    = if_id_q[15:0];
    assign funct  = if_id_q[5:0];

    alu_op_e  dec_op;
    logic     dec_we;
    reg_idx_t dec_wd;
    logic     use_imm;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        dec_op  = ALU_NOP;
        dec_we  = 1'b0;
        dec_wd  = '0;
        use_imm = 1'b0;
        case (opcode)
            OP_ORI:  begin dec_op = ALU_OR;  dec_we = 1'b1; dec_wd = rt; use_imm = 1'b1; end
            OP_ANDI: begin dec_op = ALU_AND; dec_we = 1'b1; dec_wd = rt; use_imm = 1'b1; end
            OP_XORI: begin dec_op = ALU_XOR; dec_we = 1'b1; dec_wd = rt; use_imm = 1'b1; end
            OP_LUI:  begin dec_op = ALU_LUI; dec_we = 1'b1; dec_wd = rt; use_imm = 1'b1; end
            OP_SPECIAL: begin
                case (funct)
                    FN_AND:  begin dec_op = ALU_AND; dec_we = 1'b1; dec_wd = rd; end
                    FN_OR:   begin dec_op = ALU_OR;  dec_we = 1'b1; dec_wd = rd; end
                    FN_XOR:  begin dec_op = ALU_XOR; dec_we = 1'b1; dec_wd = rd; end
                    FN_NOR:  begin dec_op = ALU_NOR; dec_we = 1'b1; dec_wd = rd; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Pipeline latches and register file, declared ahead of the operand read.
    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    wb_t    ex_mem_q;
    wb_t    ex_mem_d;
    wb_t    mem_wb_q;
    word_t  ex_result;
    word_t  regs [0:31];

    // Operand read with bypassing. $0 is hard-wired to zero, so no producer
    // targeting $0 can ever be selected.
    function automatic word_t read_operand(input reg_idx_t idx);
        if (idx == '0)
            return '0;
`ifdef MIPS_FORWARD_EN
        if (id_ex_q.we && id_ex_q.wd == idx)
            return ex_result;
        if (ex_mem_q.we && ex_mem_q.wd == idx)
            return ex_mem_q.data;
`endif
        if (mem_wb_q.we && mem_wb_q.wd == idx)
            return mem_wb_q.data;
        return regs[idx];
    endfunction

    word_t rs_val;
    word_t rt_val;

    always_comb begin
        rs_val  = read_operand(rs);
        rt_val  = read_operand(rt);
        id_ex_d = '{op: dec_op,
                    a:  rs_val,
                    b:  use_imm ? {16'h0000, imm} : rt_val,
                    wd: dec_wd,
                    we: dec_we};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) id_ex_q <= '{op: ALU_NOP, a: '0, b: '0, wd: '0, we: 1'b0};
        else       id_ex_q <= id_ex_d;
    end

    // ---------------------------------------------------------------- EX
    assign ex_result = alu(id_ex_q.op, id_ex_q.a, id_ex_q.b);
    assign ex_mem_d  = '{we: id_ex_q.we, wd: id_ex_q.wd, data: ex_result};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ex_mem_q <= '0;
        else       ex_mem_q <= ex_mem_d;
    end

    // --------------------------------------------------------------- MEM
    // No memory operations: the write-back bundle passes straight through.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) mem_wb_q <= '0;
        else       mem_wb_q <= ex_mem_q;
    end

    // ---------------------------------------------------------------- WB
    // NOTE: unlike the ROM, the register file must come up all-zero, so its
    // array is cleared on reset; this costs a reset net on every flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (mem_wb_q.we && mem_wb_q.wd != '0) begin
            regs[mem_wb_q.wd] <= mem_wb_q.data;
        end
    end

    // PC low bits are always zero, high bits lie beyond the ROM window, and
    // shamt is unused because SLL only appears as the NOP.
    logic unused_bits;
    assign unused_bits = ^{pc_q[31:12], pc_q[1:0], if_id_q[10:6]};

endmodule

// File: tb/tb_mips_sopc.sv
// ============================================================================
// tb_mips_sopc -- self-checking bench for mips_sopc.
// Each program is written into rom.storage while reset is held; expected
// register values are queued as (edge-after-release, register, value) and a
// monitor compares them on the falling edge that follows that rising edge.
// Expectations for dependent code follow MIPS_FORWARD_EN.
// ============================================================================
module tb_mips_sopc;

    localparam int ROM_DEPTH = 1024;

`ifdef MIPS_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock;
    logic reset;

    mips_sopc #(.ROM_DEPTH(ROM_DEPTH)) dut (
        .clock (clock),
        .reset (reset)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int          edge_n;
        int          idx;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   edge_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Rising edges since reset release (1 = first edge after release).
    always @(posedge clock or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                while (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
                    e = sb.pop_front();
                    check($sformatf("t%0d_r%0d_edge%0d", e.tag, e.idx, e.edge_n),
                          dut.regs[e.idx], e.val);
                end
            end
        end
    end

    task automatic expect_reg(input int tag, input int edge_n, input int idx, input logic [31:0] val);
        exp_t e;
        e.edge_n = edge_n;
        e.idx    = idx;
        e.val    = val;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic start_prog();
        reset = 1'b1;
        @(posedge clock);
        for (int i = 0; i < ROM_DEPTH; i++) dut.rom.storage[i] = 32'h0;
    endtask

    task automatic load(input int addr, input logic [31:0] w);
        dut.rom.storage[addr] = w;
    endtask

    task automatic drain(input int tag);
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL t%0d_timeout: got %0d pending, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic go(input int tag);
        @(negedge clock);
        reset = 1'b0;
        drain(tag);
    endtask

    initial begin
        // ---- reset state
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("reset_pc", dut.pc_q, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_r%0d", i), dut.regs[i], 32'h0);

        // ---- t1: single ORI, latency 5
        start_prog();
        load(0, 32'h34011100);
        expect_reg(1, 4, 1, 32'h0);
        expect_reg(1, 5, 1, 32'h00001100);
        go(1);

        // ---- t2: back-to-back dependency
        start_prog();
        load(0, 32'h34011100);
        load(1, 32'h34220020);
        expect_reg(2, 5, 1, 32'h00001100);
        expect_reg(2, 6, 2, FWD ? 32'h00001120 : 32'h00000020);
        go(2);

        // ---- t3: LUI + R-type, plus XOR / ANDI through the register file
        start_prog();
        load(0, 32'h3C031234);   // lui  $3,0x1234
        load(1, 32'h34011100);   // ori  $1,$0,0x1100
        load(2, 32'h00612025);   // or   $4,$3,$1
        load(3, 32'h00612827);   // nor  $5,$3,$1
        load(4, 32'h00614826);   // xor  $9,$3,$1
        load(5, 32'h302A0300);   // andi $10,$1,0x0300
        expect_reg(3, 5, 3, 32'h12340000);
        expect_reg(3, 6, 1, 32'h00001100);
        expect_reg(3, 7, 4, FWD ? 32'h12341100 : 32'h00000000);
        expect_reg(3, 8, 5, FWD ? 32'hEDCBEEFF : 32'hEDCBFFFF);
        expect_reg(3, 9, 9, 32'h12341100);
        expect_reg(3, 10, 10, 32'h00000100);
        go(3);

        // ---- t4: $0 protection (write ignored, never forwarded)
        start_prog();
        load(0, 32'h3400FFFF);   // ori  $0,$0,0xFFFF
        load(1, 32'h34060000);   // ori  $6,$0,0
        load(2, 32'h38070F0F);   // xori $7,$0,0x0F0F
        load(4, 32'h380800AA);   // xori $8,$0,0x00AA
        expect_reg(4, 5, 0, 32'h0);
        expect_reg(4, 6, 6, 32'h0);
        expect_reg(4, 7, 7, 32'h00000F0F);
        expect_reg(4, 9, 8, 32'h000000AA);
        go(4);

        // ---- t5: unsupported opcode (LW) retires as NOP
        start_prog();
        load(0, 32'h8C010004);   // lw   $1,4($0)
        load(1, 32'h34010055);   // ori  $1,$0,0x55
        expect_reg(5, 5, 1, 32'h0);
        expect_reg(5, 6, 1, 32'h00000055);
        go(5);

        // ---- t6: reset asserted mid-program
        start_prog();
        load(0, 32'h34011100);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("t6_pc_before_reset", dut.pc_q, 32'h8);
        #1;
        reset = 1'b1;
        #1;
        check("t6_pc_after_reset", dut.pc_q, 32'h0);
        check("t6_if_id_after_reset", dut.if_id_q, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("t6_r%0d_after_reset", i), dut.regs[i], 32'h0);
        expect_reg(6, 3, 1, 32'h0);
        expect_reg(6, 4, 1, 32'h0);
        expect_reg(6, 5, 1, 32'h00001100);
        go(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
